// File: rtl/pc_sequencer.sv
// Program-counter sequencer: reset/trap/stall/branch/return/jump/sequential next-PC selection.
// Define PC_SEQUENCER_RAS_EN to compile in the return-address stack (Call pushes, Ret pops).
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h80),
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             Stall,
    input  logic             Trap,
    input  logic             BrTaken,
    input  logic [WIDTH-1:0] BrTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic             Ret,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus,
    output logic             MisalignErr,
    output logic             RasEmpty,
    output logic             RasUnderflow
);

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic             misalign_q, misalign_d;

    // Wraps modulo 2^WIDTH by construction.
    assign pc_plus = pc_q + STEP_W;

    function automatic logic misaligned(input logic [WIDTH-1:0] target);
        return |(target & ALIGN_MASK);
    endfunction

`ifdef PC_SEQUENCER_RAS_EN
    localparam int unsigned      PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q;
    logic             underflow_q, underflow_d;
    logic             push, pop, replace;
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;
`endif

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        pc_d       = pc_plus;
        misalign_d = 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
        underflow_d = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        replace     = 1'b0;
`endif
        if (Trap) begin
            pc_d = TRAP_VECTOR;
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (BrTaken) begin
            if (misaligned(BrTarget)) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
            end else begin
                pc_d = BrTarget;
            end
        end
`ifdef PC_SEQUENCER_RAS_EN
        else if (Ret) begin
            // Return addresses are trusted: no alignment check on the popped value.
            if (cnt_q != '0) begin
                pc_d    = ras_q[top_q];
                replace = Jump && Call;
                pop     = !(Jump && Call);
            end else begin
                underflow_d = 1'b1;
            end
        end
`endif
        else if (Jump) begin
            if (misaligned(JumpTarget)) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
            end else begin
                pc_d = JumpTarget;
            end
`ifdef PC_SEQUENCER_RAS_EN
            push = Call;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (R) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_SEQUENCER_RAS_EN
    // Circular stack: when full, the slot after top holds the oldest entry and is overwritten.
    always_comb begin
        top_d     = top_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = top_q;
        if (push) begin
            top_d     = top_q + PTR_W'(1);
            ras_waddr = top_q + PTR_W'(1);
            ras_we    = 1'b1;
            if (cnt_q != FULL_CNT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end else if (replace) begin
            ras_we = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (R) begin
            top_q       <= '0;
            cnt_q       <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            top_q       <= top_d;
            cnt_q       <= cnt_d;
            empty_q     <= (cnt_d == '0);
            underflow_q <= underflow_d;
        end
    end

    // NOTE: entry storage has no reset; cnt_q alone decides which entries are valid.
    always_ff @(posedge Clk) begin
        if (ras_we && !R) begin
            ras_q[ras_waddr] <= pc_plus;
        end
    end

    assign RasEmpty     = empty_q;
    assign RasUnderflow = underflow_q;
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ras;
    assign unused_ras   = Call ^ Ret;
    assign RasEmpty     = 1'b1;
    assign RasUnderflow = 1'b0;
`endif

    assign PC          = pc_q;
    assign PCPlus      = pc_plus;
    assign MisalignErr = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; RAS vectors follow PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;

    logic        Clk        = 1'b0;
    logic        R          = 1'b1;
    logic        Stall      = 1'b0;
    logic        Trap       = 1'b0;
    logic        BrTaken    = 1'b0;
    logic [31:0] BrTarget   = '0;
    logic        Jump       = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic        Call       = 1'b0;
    logic        Ret        = 1'b0;
    logic [31:0] PC, PCPlus;
    logic        MisalignErr, RasEmpty, RasUnderflow;

    logic        r8     = 1'b1;
    logic        jump8  = 1'b0;
    logic [7:0]  jt8    = '0;
    logic [7:0]  pc8, pcplus8;
    logic        mis8, empty8, uf8;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    pc_sequencer u_dut (
        .Clk(Clk), .R(R), .Stall(Stall), .Trap(Trap),
        .BrTaken(BrTaken), .BrTarget(BrTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Call(Call), .Ret(Ret),
        .PC(PC), .PCPlus(PCPlus), .MisalignErr(MisalignErr),
        .RasEmpty(RasEmpty), .RasUnderflow(RasUnderflow)
    );

    pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80)) u_dut8 (
        .Clk(Clk), .R(r8), .Stall(1'b0), .Trap(1'b0),
        .BrTaken(1'b0), .BrTarget(8'h00),
        .Jump(jump8), .JumpTarget(jt8), .Call(1'b0), .Ret(1'b0),
        .PC(pc8), .PCPlus(pcplus8), .MisalignErr(mis8),
        .RasEmpty(empty8), .RasUnderflow(uf8)
    );

    typedef struct {
        logic        r, stall, trap, br;
        logic [31:0] brt;
        logic        jump;
        logic [31:0] jt;
        logic        call, ret;
        logic [31:0] pc;
        logic        mis, uf, empty;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic stall, input logic trap,
                                input logic br, input logic [31:0] brt,
                                input logic jump, input logic [31:0] jt,
                                input logic call, input logic ret,
                                input logic [31:0] pc, input logic mis,
                                input logic uf, input logic empty);
        vec_t v;
        v.r = r; v.stall = stall; v.trap = trap; v.br = br; v.brt = brt;
        v.jump = jump; v.jt = jt; v.call = call; v.ret = ret;
        v.pc = pc; v.mis = mis; v.uf = uf; v.empty = empty;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        R = v.r; Stall = v.stall; Trap = v.trap; BrTaken = v.br; BrTarget = v.brt;
        Jump = v.jump; JumpTarget = v.jt; Call = v.call; Ret = v.ret;
        @(posedge Clk);
        #1;
        check({tag, ".pc"},     PC,                  v.pc);
        check({tag, ".pcplus"}, PCPlus,              v.pc + 32'd4);
        check({tag, ".mis"},    32'(MisalignErr),    32'(v.mis));
        check({tag, ".uf"},     32'(RasUnderflow),   32'(v.uf));
        check({tag, ".empty"},  32'(RasEmpty),       32'(v.empty));
    endtask

    vec_t tbl[$];
    vec_t ras[$];

    initial begin
        //                r  st tr br brt      j  jt       c  rt  pc       mis uf emp
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h4,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h8,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'hc,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h10,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h10,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h10,  0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h80,  0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h200, 1, 32'h300, 0, 0, 32'h200, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h202, 1, 32'h300, 0, 0, 32'h80,  1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h84,  0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h101, 0, 0, 32'h80,  1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h300, 0, 0, 32'h300, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h500, 1, 0, 32'h304, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h200, 0, 32'h0,   0, 0, 32'h80,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 32'h400, 0, 32'h0,   0, 0, 32'h80,  0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h4,   0, 0, 1));

`ifdef PC_SEQUENCER_RAS_EN
        ras.push_back(mk(1, 0, 0, 0, 32'h0,   1, 32'h100, 1, 0, 32'h0,   0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h100, 1, 0, 32'h100, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h200, 1, 0, 32'h200, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h300, 1, 0, 32'h300, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h400, 1, 0, 32'h400, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h500, 1, 0, 32'h500, 0, 0, 0));
        ras.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h500, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h404, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h304, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h204, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h104, 0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h108, 0, 1, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h10c, 0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h600, 1, 0, 32'h600, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h700, 1, 1, 32'h110, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h604, 0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h800, 1, 0, 32'h800, 0, 0, 0));
        ras.push_back(mk(0, 0, 0, 1, 32'h900, 1, 32'ha00, 1, 1, 32'h900, 0, 0, 0));
        ras.push_back(mk(0, 0, 1, 0, 32'h0,   1, 32'ha00, 1, 1, 32'h80,  0, 0, 0));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h608, 0, 0, 1));
        ras.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h608, 0, 0, 1));
        ras.push_back(mk(1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h0,   0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h4,   0, 1, 1));
`else
        ras.push_back(mk(1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h100, 1, 0, 32'h100, 0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h104, 0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h300, 0, 1, 32'h300, 0, 0, 1));
        ras.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h101, 1, 0, 32'h80,  1, 0, 1));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("base%0d", i));
        end
        for (int i = 0; i < ras.size(); i++) begin
            run_vec(ras[i], $sformatf("ras%0d", i));
        end

        // 8-bit instance: jump to 0xFC then step once to see the modulo wrap.
        r8 = 1'b1;
        @(posedge Clk);
        #1;
        check("w8.reset_pc", 32'(pc8), 32'h0);
        r8 = 1'b0; jump8 = 1'b1; jt8 = 8'hfc;
        @(posedge Clk);
        #1;
        check("w8.pc_fc",     32'(pc8),     32'hfc);
        check("w8.pcplus_fc", 32'(pcplus8), 32'h0);
        jump8 = 1'b0;
        @(posedge Clk);
        #1;
        check("w8.wrap_pc", 32'(pc8),   32'h0);
        check("w8.mis",     32'(mis8),  32'h0);
        check("w8.empty",   32'(empty8), 32'h1);
        check("w8.uf",      32'(uf8),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, sets the PC and target bit width.
REQ-002 Parameter RESET_VECTOR, default 0, is the PC value after reset.
REQ-003 Parameter TRAP_VECTOR, default 'h80, is the PC value loaded on a trap or a misaligned redirect.
REQ-004 Parameter STEP, default 4, is the sequential increment and SHALL be a power of two; ALIGN = log2(STEP).
REQ-005 Parameter RAS_DEPTH, default 4, is the number of return-address-stack entries and SHALL be a power of two of at least 2.
REQ-006 Ports, in this order:
- Clk  in  1  clock; all state updates on rising edge.
- R  in  1  synchronous active-high reset.
- Stall  in  1  hold PC and RAS.
- Trap  in  1  redirect to TRAP_VECTOR.
- BrTaken  in  1  redirect to BrTarget.
- BrTarget  in  WIDTH  branch target.
- Jump  in  1  redirect to JumpTarget.
- JumpTarget  in  WIDTH  jump target.
- Call  in  1  qualifies Jump; pushes the return address.
- Ret  in  1  pop the RAS and redirect to the popped value.
- PC  out  WIDTH  registered current PC.
- PCPlus  out  WIDTH  PC+STEP, combinational from PC.
- MisalignErr  out  1  registered one-cycle pulse.
- RasEmpty  out  1  registered; RAS holds no entries.
- RasUnderflow  out  1  registered one-cycle pulse.

Function
REQ-007 Next-PC priority per rising edge SHALL be R > Trap > Stall > BrTaken > Ret > Jump > sequential (PC+STEP).
REQ-008 Every PC change SHALL be visible on PC the cycle after the qualifying edge; latency is 1 cycle.
REQ-009 Stall SHALL hold PC, the RAS and its count unchanged, and SHALL force MisalignErr and RasUnderflow low for that cycle.
REQ-010 Trap SHALL load TRAP_VECTOR even while Stall is high, and SHALL leave the RAS unchanged.
REQ-011 A selected BrTarget or JumpTarget with nonzero bits [ALIGN-1:0] SHALL load TRAP_VECTOR and pulse MisalignErr for one cycle.
REQ-012 Sequential increment SHALL wrap modulo 2^WIDTH; for example, PC = 2^WIDTH-STEP goes to 0.
REQ-013 When Jump and Call win, the RAS SHALL push PCPlus.
REQ-014 When the RAS is full, a push SHALL overwrite the oldest entry (circular), and the count SHALL saturate at RAS_DEPTH.
REQ-015 When Ret wins and the RAS is non-empty, PC SHALL load the top entry and the count SHALL decrement by 1.
REQ-016 When Ret wins and the RAS is empty, PC SHALL take the sequential value, RasUnderflow SHALL pulse for one cycle, and the count SHALL stay 0.
REQ-017 When Ret wins with Jump and Call also asserted, PC SHALL load the popped value, and the popped top SHALL be replaced by PCPlus, leaving the count unchanged.
REQ-018 When BrTaken or Trap wins, Call and Ret SHALL be ignored and the RAS SHALL be unchanged.
REQ-019 A popped return address SHALL NOT be alignment-checked.
REQ-020 Call without Jump SHALL have no effect.

Reset
REQ-021 When R is high at a rising edge, PC SHALL become RESET_VECTOR, the RAS count SHALL become 0, RasEmpty SHALL become 1, and MisalignErr and RasUnderflow SHALL become 0.
REQ-022 R SHALL override every other input on the same edge, including mid-push, mid-pop and Stall.
REQ-023 RAS entry contents need not be cleared on reset.

Configuration
REQ-024 Macro PC_SEQUENCER_RAS_EN, when defined, SHALL compile in the RAS and the behaviour of REQ-013 to REQ-017.
REQ-025 When PC_SEQUENCER_RAS_EN is undefined:
- Call and Ret SHALL be ignored.
- RasEmpty SHALL be tied to 1 and RasUnderflow to 0.
- No RAS storage SHALL be synthesised.
- The remaining behaviour SHALL be unchanged.

Verification
REQ-026 Reset sequential run: R=1 for 1 cycle, then idle for 3 cycles -> PC = 0, 4, 8, 12.
REQ-027 Stall versus Trap: PC = 'h10 with Stall=1 for 2 cycles -> PC stays 'h10; then Stall=1 and Trap=1 -> PC = 'h80.
REQ-028 Branch priority and alignment:
- BrTaken=1, BrTarget='h200, Jump=1, JumpTarget='h300 -> PC = 'h200.
- Then BrTarget='h202 -> PC = 'h80 and MisalignErr pulses.
REQ-029 RAS depth and underflow (RAS_DEPTH=4, macro defined):
- Five Call+Jump from PC = 'h0, 'h100, 'h200, 'h300, 'h400 pushing 'h4, 'h104, 'h204, 'h304, 'h404.
- Four Rets -> PC = 'h404, 'h304, 'h204, 'h104.
- A fifth Ret -> PC = previous+4 and RasUnderflow pulses.
REQ-030 Wrap-around: WIDTH=8, PC = 'hFC, idle -> PC = 'h00.
REQ-031 Macro undefined: Call+Jump to 'h100, then Ret -> PC = 'h104, RasEmpty = 1, RasUnderflow = 0.
